// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_MAX_WAIT = 8;
  localparam int unsigned BE_W         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } arb_state_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage has priority; the debug/loader port
// is served when the pipeline is idle, when the core is frozen, or when the
// starvation counter forces a one-cycle pipeline stall.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              debug,
  input  logic              pipe_memread,
  input  logic              pipe_memwrite,
  input  logic [3:0]        pipe_byte_en,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [3:0]        dbg_req_be,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(MAX_WAIT - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic pipe_access;
  logic starve;
  logic grant;

  // Grant decision; held off entirely while reset is asserted
  always_comb begin
    pipe_access = pipe_memread | pipe_memwrite;
    starve      = (wait_cnt_q == STARVE_CNT);
    grant       = Rst & (state_q == IDLE) & dbg_req_valid &
                  (~pipe_access | debug | starve);
  end

  assign dbg_req_ready = grant;
  assign pipe_stall    = grant & pipe_access & ~debug;
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;

  // Memory port mux: debug only on the granted cycle, pipeline otherwise
  always_comb begin
    mem_we   = pipe_memwrite;
    mem_en   = pipe_byte_en;
    mem_addr = pipe_addr;
    mem_din  = pipe_wdata;
    if (grant) begin
      mem_we   = dbg_req_we;
      mem_en   = dbg_req_be;
      mem_addr = dbg_req_addr;
      mem_din  = dbg_req_wdata;
    end
  end

  // Next-state, response data and starvation counter
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    wait_cnt_d  = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          if (dbg_req_we) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (dbg_req_valid) begin
          // Saturate at the starve threshold
          if (wait_cnt_q != STARVE_CNT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end
      end
      RD_WAIT: begin
        // Read data for the granted address arrives this cycle
        state_d     = RESP;
        rsp_rdata_d = mem_dout;
      end
      RESP: begin
        if (dbg_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-enabled sync RAM.
module tb_dmem_arbiter;

  logic        clk;
  logic        Rst;
  logic        debug;
  logic        pipe_memread;
  logic        pipe_memwrite;
  logic [3:0]  pipe_byte_en;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_we;
  logic [3:0]  dbg_req_be;
  logic [7:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  logic        mem_we;
  logic [3:0]  mem_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic        ram_clr;
  logic [31:0] ram [0:63];

  int total;
  int bad;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk           (clk),
    .Rst           (Rst),
    .debug         (debug),
    .pipe_memread  (pipe_memread),
    .pipe_memwrite (pipe_memwrite),
    .pipe_byte_en  (pipe_byte_en),
    .pipe_addr     (pipe_addr),
    .pipe_wdata    (pipe_wdata),
    .pipe_stall    (pipe_stall),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_we    (dbg_req_we),
    .dbg_req_be    (dbg_req_be),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_ready (dbg_rsp_ready),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .mem_we        (mem_we),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-organised RAM, byte lanes, read-first, one-cycle read latency
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_en[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
      end
    end
    mem_dout <= ram[mem_addr[7:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg_idle();
    dbg_req_valid = 1'b0;
    dbg_req_we    = 1'b0;
    dbg_req_be    = 4'h0;
    dbg_req_addr  = 8'h00;
    dbg_req_wdata = 32'h0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    Rst = 1'b0;
    ram_clr = 1'b1;
    debug = 1'b0;
    pipe_memread = 1'b0;
    pipe_memwrite = 1'b0;
    pipe_byte_en = 4'h0;
    pipe_addr = 8'h00;
    pipe_wdata = 32'h0;
    dbg_rsp_ready = 1'b0;
    dbg_idle();

    // Reset: outputs forced, mux on pipeline even with a pending request
    step();
    step();
    pipe_memread = 1'b1;
    pipe_addr = 8'h14;
    dbg_req_valid = 1'b1;
    dbg_req_addr = 8'h10;
    settle();
    chk("rst_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rst_rdata",     dbg_rsp_rdata,      32'd0);
    chk("rst_ready",     32'(dbg_req_ready), 32'd0);
    chk("rst_stall",     32'(pipe_stall),    32'd0);
    chk("rst_mux_addr",  32'(mem_addr),      32'h14);

    // Leave reset; pipeline stores 0x12345678 at 0x14
    step();
    Rst = 1'b1;
    ram_clr = 1'b0;
    dbg_idle();
    pipe_memread = 1'b0;
    pipe_memwrite = 1'b1;
    pipe_byte_en = 4'hF;
    pipe_addr = 8'h14;
    pipe_wdata = 32'h1234_5678;
    settle();
    chk("preload_we", 32'(mem_we), 32'd1);

    // Idle pipeline, debug write 0x10 = DEADBEEF
    step();
    pipe_memwrite = 1'b0;
    pipe_byte_en = 4'h0;
    pipe_addr = 8'h00;
    pipe_wdata = 32'h0;
    dbg_req_valid = 1'b1;
    dbg_req_we = 1'b1;
    dbg_req_be = 4'hF;
    dbg_req_addr = 8'h10;
    dbg_req_wdata = 32'hDEAD_BEEF;
    settle();
    chk("wr_ready", 32'(dbg_req_ready), 32'd1);
    chk("wr_stall", 32'(pipe_stall),    32'd0);
    chk("wr_mem_we", 32'(mem_we),       32'd1);
    chk("wr_mem_addr", 32'(mem_addr),   32'h10);
    chk("wr_mem_din", mem_din,          32'hDEAD_BEEF);

    step();
    dbg_idle();
    dbg_rsp_ready = 1'b1;
    settle();
    chk("wr_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("wr_rsp_rdata", dbg_rsp_rdata,      32'd0);

    // Debug read 0x10
    step();
    dbg_rsp_ready = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_we = 1'b0;
    dbg_req_addr = 8'h10;
    settle();
    chk("rd_ready", 32'(dbg_req_ready), 32'd1);
    chk("rd_rsp_valid_n", 32'(dbg_rsp_valid), 32'd0);

    step();
    dbg_idle();
    settle();
    chk("rd_wait_valid", 32'(dbg_rsp_valid), 32'd0);

    step();
    settle();
    chk("rd_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("rd_rsp_rdata", dbg_rsp_rdata,      32'hDEAD_BEEF);
    dbg_rsp_ready = 1'b1;

    // Starvation: continuous pipeline loads of 0x14, debug read 0x10 held
    step();
    dbg_rsp_ready = 1'b0;
    pipe_memread = 1'b1;
    pipe_addr = 8'h14;
    dbg_req_valid = 1'b1;
    dbg_req_we = 1'b0;
    dbg_req_addr = 8'h10;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      settle();
      if (k < 7) begin
        chk($sformatf("starve_ready_c%0d", k), 32'(dbg_req_ready), 32'd0);
        chk($sformatf("starve_stall_c%0d", k), 32'(pipe_stall),    32'd0);
        chk($sformatf("starve_addr_c%0d", k),  32'(mem_addr),      32'h14);
      end else begin
        chk("starve_ready_c7", 32'(dbg_req_ready), 32'd1);
        chk("starve_stall_c7", 32'(pipe_stall),    32'd1);
        chk("starve_addr_c7",  32'(mem_addr),      32'h10);
      end
      if (k > 0) chk($sformatf("starve_pipe_data_c%0d", k), mem_dout, 32'h1234_5678);
    end

    step();
    dbg_idle();
    settle();
    chk("starve_after_stall", 32'(pipe_stall), 32'd0);
    chk("starve_after_addr",  32'(mem_addr),   32'h14);
    chk("starve_dbg_dout",    mem_dout,        32'hDEAD_BEEF);

    step();
    settle();
    chk("starve_replay_data", mem_dout,           32'h1234_5678);
    chk("starve_rsp_valid",   32'(dbg_rsp_valid), 32'd1);
    chk("starve_rsp_rdata",   dbg_rsp_rdata,      32'hDEAD_BEEF);
    pipe_memread = 1'b0;
    pipe_addr = 8'h00;
    dbg_rsp_ready = 1'b1;

    // Reset during RD_WAIT drops the transaction
    step();
    dbg_rsp_ready = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_addr = 8'h14;
    settle();
    chk("rstrd_ready", 32'(dbg_req_ready), 32'd1);

    step();
    dbg_idle();
    Rst = 1'b0;
    settle();
    chk("rstrd_wait_valid", 32'(dbg_rsp_valid), 32'd0);

    step();
    Rst = 1'b1;
    settle();
    chk("rstrd_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rstrd_rdata", dbg_rsp_rdata,      32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      settle();
      chk($sformatf("rstrd_no_rsp_%0d", k), 32'(dbg_rsp_valid), 32'd0);
    end

    // debug=1 with pipeline store: debug read granted, no stall
    step();
    debug = 1'b1;
    pipe_memwrite = 1'b1;
    pipe_byte_en = 4'hF;
    pipe_addr = 8'h30;
    pipe_wdata = 32'hFFFF_FFFF;
    dbg_req_valid = 1'b1;
    dbg_req_we = 1'b0;
    dbg_req_addr = 8'h14;
    settle();
    chk("dbgmode_ready",  32'(dbg_req_ready), 32'd1);
    chk("dbgmode_stall",  32'(pipe_stall),    32'd0);
    chk("dbgmode_mem_we", 32'(mem_we),        32'd0);
    chk("dbgmode_addr",   32'(mem_addr),      32'h14);

    // Second request (write 0x18) held valid while response is back-pressured
    step();
    debug = 1'b0;
    pipe_memwrite = 1'b0;
    pipe_byte_en = 4'h0;
    pipe_addr = 8'h00;
    pipe_wdata = 32'h0;
    dbg_req_valid = 1'b1;
    dbg_req_we = 1'b1;
    dbg_req_be = 4'hF;
    dbg_req_addr = 8'h18;
    dbg_req_wdata = 32'hCAFE_F00D;
    settle();
    chk("bp_rdwait_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("bp_rdwait_ready", 32'(dbg_req_ready), 32'd0);

    for (int k = 0; k < 5; k++) begin
      step();
      settle();
      chk($sformatf("bp_valid_%0d", k), 32'(dbg_rsp_valid), 32'd1);
      chk($sformatf("bp_rdata_%0d", k), dbg_rsp_rdata,      32'h1234_5678);
      chk($sformatf("bp_ready_%0d", k), 32'(dbg_req_ready), 32'd0);
    end

    step();
    dbg_rsp_ready = 1'b1;
    settle();
    chk("bp_hs_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("bp_hs_ready", 32'(dbg_req_ready), 32'd0);

    step();
    dbg_rsp_ready = 1'b0;
    settle();
    chk("b2b_ready",     32'(dbg_req_ready), 32'd1);
    chk("b2b_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("b2b_mem_we",    32'(mem_we),        32'd1);
    chk("b2b_mem_addr",  32'(mem_addr),      32'h18);

    step();
    dbg_idle();
    dbg_rsp_ready = 1'b1;
    settle();
    chk("b2b_rsp_valid_wr", 32'(dbg_rsp_valid), 32'd1);
    chk("b2b_rsp_rdata_wr", dbg_rsp_rdata,      32'd0);

    // Pipeline byte store to 0x23 while a debug read of 0x18 waits
    step();
    dbg_rsp_ready = 1'b0;
    pipe_memwrite = 1'b1;
    pipe_byte_en = 4'b1000;
    pipe_addr = 8'h23;
    pipe_wdata = 32'hAB00_0000;
    dbg_req_valid = 1'b1;
    dbg_req_we = 1'b0;
    dbg_req_addr = 8'h18;
    settle();
    chk("sb_ready",  32'(dbg_req_ready), 32'd0);
    chk("sb_stall",  32'(pipe_stall),    32'd0);
    chk("sb_mem_we", 32'(mem_we),        32'd1);
    chk("sb_mem_en", 32'(mem_en),        32'h8);
    chk("sb_addr",   32'(mem_addr),      32'h23);
    chk("sb_din",    mem_din,            32'hAB00_0000);

    step();
    pipe_memwrite = 1'b0;
    pipe_byte_en = 4'h0;
    pipe_memread = 1'b1;
    pipe_addr = 8'h20;
    pipe_wdata = 32'h0;
    settle();
    chk("sb_ld_ready", 32'(dbg_req_ready), 32'd0);

    step();
    pipe_memread = 1'b0;
    pipe_addr = 8'h00;
    settle();
    chk("sb_ld_data",  mem_dout,            32'hAB00_0000);
    chk("sb_dbg_ready", 32'(dbg_req_ready), 32'd1);
    chk("sb_dbg_addr",  32'(mem_addr),      32'h18);

    step();
    dbg_idle();
    step();
    settle();
    chk("sb_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("sb_rsp_rdata", dbg_rsp_rdata,      32'hCAFE_F00D);
    dbg_rsp_ready = 1'b1;

    step();
    dbg_rsp_ready = 1'b0;
    settle();
    chk("final_idle_valid", 32'(dbg_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dmem_arbiter
